// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: memory control bus layout, access sizes
// and the MEM-stage state encoding.
package mips_pkg;

  localparam int MEM_READ  = 0;
  localparam int MEM_WRITE = 1;
  localparam int BRANCH    = 2;
  localparam int SIZE_LO   = 3;
  localparam int SIZE_HI   = 4;
  localparam int LOAD_UNS  = 5;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  // Size code 2'b11 behaves as a word access.
  function automatic logic addr_aligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic ok;
    case (size)
      SZ_BYTE: ok = 1'b1;
      SZ_HALF: ok = ~addr_lo[0];
      default: ok = (addr_lo == 2'b00);
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory request/acknowledge bus between the MEM stage (master) and the
// data memory (slave).
interface mem_access_stage_if #(
  parameter int ADDR_BITS  = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  dmem_req;
  logic                  dmem_we;
  logic [ADDR_BITS-1:0]  dmem_addr;
  logic [DATA_WIDTH-1:0] dmem_wdata;
  logic [3:0]            dmem_be;
  logic [DATA_WIDTH-1:0] dmem_rdata;
  logic                  dmem_ack;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    output dmem_rdata, dmem_ack
  );
endinterface

// File: rtl/mem_lane_align.sv
// Little-endian lane steering for a 32-bit data bus: store byte enables and
// data replication, plus load lane extraction with sign/zero extension.
module mem_lane_align
  import mips_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        load_unsigned,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] load_word,
  output logic [3:0]  byte_en,
  output logic [31:0] store_word,
  output logic [31:0] load_data
);

  logic [7:0]  load_byte;
  logic [15:0] load_half;

  always_comb begin
    case (addr_lo)
      2'd0:    load_byte = load_word[7:0];
      2'd1:    load_byte = load_word[15:8];
      2'd2:    load_byte = load_word[23:16];
      default: load_byte = load_word[31:24];
    endcase
    load_half = addr_lo[1] ? load_word[31:16] : load_word[15:0];
  end

  always_comb begin
    byte_en    = 4'b1111;
    store_word = store_data;
    load_data  = load_word;
    case (size)
      SZ_BYTE: begin
        byte_en    = 4'b0001 << addr_lo;
        store_word = {4{store_data[7:0]}};
        load_data  = load_unsigned ? {24'b0, load_byte} : {{24{load_byte[7]}}, load_byte};
      end
      SZ_HALF: begin
        byte_en    = addr_lo[1] ? 4'b1100 : 4'b0011;
        store_word = {2{store_data[15:0]}};
        load_data  = load_unsigned ? {16'b0, load_half} : {{16{load_half[15]}}, load_half};
      end
      default: begin
        byte_en    = 4'b1111;
        store_word = store_data;
        load_data  = load_word;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MIPS MEM stage: resolves branches, runs loads/stores over the dmem req/ack
// bus while stalling upstream, and registers the MEM/WB outputs.
module mem_access_stage
  import mips_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_BITS      = 32,
  parameter int MEM_BUS_WIDTH  = 6,
  parameter int WB_BUS_WIDTH   = 2,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      valid_in,
  input  logic [MEM_BUS_WIDTH-1:0]  memory_bus_in,
  input  logic [WB_BUS_WIDTH-1:0]   wb_bus_in,
  input  logic [DATA_WIDTH-1:0]     alu_result_in,
  input  logic [DATA_WIDTH-1:0]     reg_rt_data_in,
  input  logic [REG_ADDR_WIDTH-1:0] add_reg_w_in,
  input  logic [ADDR_BITS-1:0]      next_pc_in,
  input  logic                      alu_zero_flag_in,
  output logic                      pc_src_out,
  output logic [ADDR_BITS-1:0]      branch_pc_out,
  output logic                      stall_out,
  mem_access_stage_if.master        dmem,
  output logic                      valid_out,
  output logic [DATA_WIDTH-1:0]     read_data_out,
  output logic [DATA_WIDTH-1:0]     alu_result_out,
  output logic [REG_ADDR_WIDTH-1:0] add_reg_w_out,
  output logic [WB_BUS_WIDTH-1:0]   wb_bus_out,
  output logic                      misaligned_out
);

  state_e state_q, state_d;

  logic                      dmem_req_q, dmem_req_d;
  logic                      dmem_we_q, dmem_we_d;
  logic [ADDR_BITS-1:0]      dmem_addr_q, dmem_addr_d;
  logic [DATA_WIDTH-1:0]     dmem_wdata_q, dmem_wdata_d;
  logic [3:0]                dmem_be_q, dmem_be_d;

  logic                      valid_out_q, valid_out_d;
  logic                      misaligned_q, misaligned_d;
  logic [DATA_WIDTH-1:0]     read_data_q, read_data_d;
  logic [DATA_WIDTH-1:0]     alu_result_q, alu_result_d;
  logic [REG_ADDR_WIDTH-1:0] add_reg_w_q, add_reg_w_d;
  logic [WB_BUS_WIDTH-1:0]   wb_bus_q, wb_bus_d;

  logic [DATA_WIDTH-1:0]     hold_alu_q, hold_alu_d;
  logic [WB_BUS_WIDTH-1:0]   hold_wb_q, hold_wb_d;
  logic [REG_ADDR_WIDTH-1:0] hold_dest_q, hold_dest_d;
  logic [1:0]                hold_size_q, hold_size_d;
  logic                      hold_uns_q, hold_uns_d;
  logic                      hold_write_q, hold_write_d;

  logic       mem_read, mem_write, is_branch, load_uns;
  logic [1:0] acc_size;
  logic       access, aligned, start, in_wait;

  assign mem_read  = memory_bus_in[MEM_READ];
  assign mem_write = memory_bus_in[MEM_WRITE];
  assign is_branch = memory_bus_in[BRANCH];
  assign load_uns  = memory_bus_in[LOAD_UNS];
  assign acc_size  = memory_bus_in[SIZE_HI:SIZE_LO];

  assign in_wait = (state_q == WAIT);
  assign access  = valid_in & (mem_read | mem_write);
  assign aligned = addr_aligned(acc_size, alu_result_in[1:0]);
  assign start   = ~in_wait & access & aligned;

  assign stall_out     = start | (in_wait & ~dmem.dmem_ack);
  assign pc_src_out    = valid_in & is_branch & alu_zero_flag_in & ~in_wait;
  assign branch_pc_out = next_pc_in;

  // One aligner serves both directions: incoming instruction while idle,
  // captured access while waiting for the load word.
  logic [1:0]  lane_size;
  logic        lane_uns;
  logic [1:0]  lane_lo;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  logic [31:0] lane_load;

  assign lane_size = in_wait ? hold_size_q     : acc_size;
  assign lane_uns  = in_wait ? hold_uns_q      : load_uns;
  assign lane_lo   = in_wait ? hold_alu_q[1:0] : alu_result_in[1:0];

  mem_lane_align u_lane_align (
    .size          (lane_size),
    .load_unsigned (lane_uns),
    .addr_lo       (lane_lo),
    .store_data    (reg_rt_data_in),
    .load_word     (dmem.dmem_rdata),
    .byte_en       (lane_be),
    .store_word    (lane_wdata),
    .load_data     (lane_load)
  );

  always_comb begin
    state_d      = state_q;
    dmem_req_d   = dmem_req_q;
    dmem_we_d    = dmem_we_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_wdata_d = dmem_wdata_q;
    dmem_be_d    = dmem_be_q;
    valid_out_d  = 1'b0;
    misaligned_d = 1'b0;
    read_data_d  = read_data_q;
    alu_result_d = alu_result_q;
    add_reg_w_d  = add_reg_w_q;
    wb_bus_d     = wb_bus_q;
    hold_alu_d   = hold_alu_q;
    hold_wb_d    = hold_wb_q;
    hold_dest_d  = hold_dest_q;
    hold_size_d  = hold_size_q;
    hold_uns_d   = hold_uns_q;
    hold_write_d = hold_write_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          hold_alu_d   = alu_result_in;
          hold_wb_d    = wb_bus_in;
          hold_dest_d  = add_reg_w_in;
          hold_size_d  = acc_size;
          hold_uns_d   = load_uns;
          hold_write_d = mem_write;
          dmem_req_d   = 1'b1;
          dmem_we_d    = mem_write;
          dmem_addr_d  = {alu_result_in[ADDR_BITS-1:2], 2'b00};
          dmem_be_d    = lane_be;
          dmem_wdata_d = lane_wdata;
          wb_bus_d     = '0;
          state_d      = WAIT;
        end else begin
          // Here any access is necessarily misaligned: retire it without
          // touching memory and with writeback suppressed.
          valid_out_d  = valid_in;
          misaligned_d = access;
          read_data_d  = '0;
          alu_result_d = alu_result_in;
          add_reg_w_d  = add_reg_w_in;
          wb_bus_d     = (valid_in & ~access) ? wb_bus_in : '0;
        end
      end
      WAIT: begin
        if (dmem.dmem_ack) begin
          dmem_req_d   = 1'b0;
          valid_out_d  = 1'b1;
          read_data_d  = hold_write_q ? '0 : lane_load;
          alu_result_d = hold_alu_q;
          add_reg_w_d  = hold_dest_q;
          wb_bus_d     = hold_wb_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
      dmem_be_q    <= '0;
      valid_out_q  <= 1'b0;
      misaligned_q <= 1'b0;
      read_data_q  <= '0;
      alu_result_q <= '0;
      add_reg_w_q  <= '0;
      wb_bus_q     <= '0;
      hold_alu_q   <= '0;
      hold_wb_q    <= '0;
      hold_dest_q  <= '0;
      hold_size_q  <= '0;
      hold_uns_q   <= 1'b0;
      hold_write_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      dmem_req_q   <= dmem_req_d;
      dmem_we_q    <= dmem_we_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_wdata_q <= dmem_wdata_d;
      dmem_be_q    <= dmem_be_d;
      valid_out_q  <= valid_out_d;
      misaligned_q <= misaligned_d;
      read_data_q  <= read_data_d;
      alu_result_q <= alu_result_d;
      add_reg_w_q  <= add_reg_w_d;
      wb_bus_q     <= wb_bus_d;
      hold_alu_q   <= hold_alu_d;
      hold_wb_q    <= hold_wb_d;
      hold_dest_q  <= hold_dest_d;
      hold_size_q  <= hold_size_d;
      hold_uns_q   <= hold_uns_d;
      hold_write_q <= hold_write_d;
    end
  end

  assign dmem.dmem_req   = dmem_req_q;
  assign dmem.dmem_we    = dmem_we_q;
  assign dmem.dmem_addr  = dmem_addr_q;
  assign dmem.dmem_wdata = dmem_wdata_q;
  assign dmem.dmem_be    = dmem_be_q;

  assign valid_out      = valid_out_q;
  assign misaligned_out = misaligned_q;
  assign read_data_out  = read_data_q;
  assign alu_result_out = alu_result_q;
  assign add_reg_w_out  = add_reg_w_q;
  assign wb_bus_out     = wb_bus_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed vector table, random
// accesses against a byte-lane reference model, and branch/reset sequences.
module tb_mem_access_stage;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_in = 1'b0;
  logic [5:0]  memory_bus_in = '0;
  logic [1:0]  wb_bus_in = '0;
  logic [31:0] alu_result_in = '0;
  logic [31:0] reg_rt_data_in = '0;
  logic [4:0]  add_reg_w_in = '0;
  logic [31:0] next_pc_in = '0;
  logic        alu_zero_flag_in = 1'b0;
  logic        pc_src_out;
  logic [31:0] branch_pc_out;
  logic        stall_out;
  logic        valid_out;
  logic [31:0] read_data_out;
  logic [31:0] alu_result_out;
  logic [4:0]  add_reg_w_out;
  logic [1:0]  wb_bus_out;
  logic        misaligned_out;

  mem_access_stage_if #(.ADDR_BITS(32), .DATA_WIDTH(32)) dmem_if ();

  mem_access_stage dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .valid_in         (valid_in),
    .memory_bus_in    (memory_bus_in),
    .wb_bus_in        (wb_bus_in),
    .alu_result_in    (alu_result_in),
    .reg_rt_data_in   (reg_rt_data_in),
    .add_reg_w_in     (add_reg_w_in),
    .next_pc_in       (next_pc_in),
    .alu_zero_flag_in (alu_zero_flag_in),
    .pc_src_out       (pc_src_out),
    .branch_pc_out    (branch_pc_out),
    .stall_out        (stall_out),
    .dmem             (dmem_if.master),
    .valid_out        (valid_out),
    .read_data_out    (read_data_out),
    .alu_result_out   (alu_result_out),
    .add_reg_w_out    (add_reg_w_out),
    .wb_bus_out       (wb_bus_out),
    .misaligned_out   (misaligned_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] rt;
    logic [31:0] rdata;
    int          lat;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] ld;
    logic        mis;
  } vec_t;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Reference model: byte counts and shifts of the little-endian word.
  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic m_aligned(input logic [1:0] sz, input logic [31:0] addr);
    return (int'(addr[1:0]) % nbytes(sz)) == 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [31:0] addr);
    int n = nbytes(sz);
    return 4'(((1 << n) - 1) << int'(addr[1:0]));
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] rt);
    int n = nbytes(sz);
    if (n == 4) return rt;
    if (n == 2) return {16'b0, rt[15:0]} * 32'h0001_0001;
    return {24'b0, rt[7:0]} * 32'h0101_0101;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] sz, input logic uns,
                                         input logic [31:0] addr, input logic [31:0] rdata);
    int n = nbytes(sz);
    logic [31:0] v, mask, top;
    if (n == 4) return rdata;
    mask = (32'd1 << (8 * n)) - 32'd1;
    top  = 32'd1 << (8 * n - 1);
    v = (rdata >> (8 * int'(addr[1:0]))) & mask;
    if (!uns && ((v & top) != 0)) v = v | ~mask;
    return v;
  endfunction

  task automatic run_txn(input vec_t v);
    logic       acc;
    logic [1:0] wb;
    logic [4:0] dest;
    acc  = v.rd | v.wr;
    wb   = 2'($urandom_range(1, 3));
    dest = 5'($urandom);
    @(negedge clk);
    valid_in         = 1'b1;
    memory_bus_in    = {v.uns, v.sz, 1'b0, v.wr, v.rd};
    wb_bus_in        = wb;
    add_reg_w_in     = dest;
    alu_result_in    = v.addr;
    reg_rt_data_in   = v.rt;
    alu_zero_flag_in = 1'($urandom);
    next_pc_in       = $urandom;
    #1;
    chk("stall_start", 32'(stall_out), 32'(acc & ~v.mis));
    chk("pc_src_nobranch", 32'(pc_src_out), 32'd0);
    @(posedge clk); #1;
    if (acc && !v.mis) begin
      chk("req", 32'(dmem_if.dmem_req), 32'd1);
      chk("we", 32'(dmem_if.dmem_we), 32'(v.wr));
      chk("addr", dmem_if.dmem_addr, {v.addr[31:2], 2'b00});
      chk("be", 32'(dmem_if.dmem_be), 32'(v.be));
      if (v.wr) chk("wdata", dmem_if.dmem_wdata, v.wd);
      chk("valid_req", 32'(valid_out), 32'd0);
      for (int i = 0; i < v.lat; i++) begin
        @(negedge clk); #1;
        chk("stall_wait", 32'(stall_out), 32'd1);
        @(posedge clk); #1;
        chk("req_hold", 32'(dmem_if.dmem_req), 32'd1);
        chk("be_hold", 32'(dmem_if.dmem_be), 32'(v.be));
        chk("valid_wait", 32'(valid_out), 32'd0);
      end
      @(negedge clk);
      dmem_if.dmem_ack   = 1'b1;
      dmem_if.dmem_rdata = v.rdata;
      #1;
      chk("stall_ack", 32'(stall_out), 32'd0);
      @(posedge clk); #1;
      chk("req_drop", 32'(dmem_if.dmem_req), 32'd0);
      chk("valid", 32'(valid_out), 32'd1);
      chk("read_data", read_data_out, v.ld);
      chk("wb", 32'(wb_bus_out), 32'(wb));
      chk("dest", 32'(add_reg_w_out), 32'(dest));
      chk("alu_out", alu_result_out, v.addr);
      chk("mis_clear", 32'(misaligned_out), 32'd0);
    end else begin
      chk("req_none", 32'(dmem_if.dmem_req), 32'd0);
      chk("valid", 32'(valid_out), 32'd1);
      chk("mis", 32'(misaligned_out), 32'(v.mis));
      chk("wb", 32'(wb_bus_out), v.mis ? 32'd0 : 32'(wb));
      chk("read_data", read_data_out, 32'd0);
    end
    @(negedge clk);
    valid_in           = 1'b0;
    dmem_if.dmem_ack   = 1'b0;
    dmem_if.dmem_rdata = $urandom;
    @(posedge clk); #1;
    chk("valid_pulse", 32'(valid_out), 32'd0);
    chk("mis_pulse", 32'(misaligned_out), 32'd0);
    chk("wb_idle", 32'(wb_bus_out), 32'd0);
    $display("txn rd=%0d wr=%0d sz=%0d uns=%0d addr=0x%08h lat=%0d ld=0x%08h checks=%0d",
             v.rd, v.wr, v.sz, v.uns, v.addr, v.lat, read_data_out, checks);
  endtask

  vec_t vecs[12];

  initial begin
    vec_t rv;
    logic [1:0] op;

    vecs[0]  = '{1'b0, 1'b1, SZ_WORD, 1'b0, 32'h104, 32'hDEADBEEF, 32'h0, 3, 4'b1111, 32'hDEADBEEF, 32'h0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, SZ_BYTE, 1'b0, 32'h203, 32'h0, 32'h80FF1234, 1, 4'b1000, 32'h0, 32'hFFFFFF80, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, SZ_BYTE, 1'b1, 32'h203, 32'h0, 32'h80FF1234, 0, 4'b1000, 32'h0, 32'h00000080, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, SZ_HALF, 1'b0, 32'h302, 32'h0000ABCD, 32'h0, 2, 4'b1100, 32'hABCDABCD, 32'h0, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, SZ_HALF, 1'b0, 32'h302, 32'h0, 32'hABCD0000, 1, 4'b1100, 32'h0, 32'hFFFFABCD, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, SZ_WORD, 1'b0, 32'h101, 32'h0, 32'h0, 0, 4'b0000, 32'h0, 32'h0, 1'b1};
    vecs[6]  = '{1'b0, 1'b0, SZ_WORD, 1'b0, 32'h777, 32'h0, 32'h0, 0, 4'b0000, 32'h0, 32'h0, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, SZ_BYTE, 1'b0, 32'h201, 32'h12345678, 32'h0, 0, 4'b0010, 32'h78787878, 32'h0, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, SZ_WORD, 1'b0, 32'h8, 32'h11223344, 32'h55667788, 1, 4'b1111, 32'h11223344, 32'h0, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, SZ_HALF, 1'b1, 32'h100, 32'h0, 32'h12348765, 0, 4'b0011, 32'h0, 32'h00008765, 1'b0};
    vecs[10] = '{1'b0, 1'b1, SZ_HALF, 1'b0, 32'h3, 32'h0000BEEF, 32'h0, 0, 4'b0000, 32'h0, 32'h0, 1'b1};
    vecs[11] = '{1'b1, 1'b0, 2'b11, 1'b0, 32'h40, 32'h0, 32'hCAFEF00D, 2, 4'b1111, 32'h0, 32'hCAFEF00D, 1'b0};

    // Reset state with rst_n held low.
    dmem_if.dmem_ack   = 1'b0;
    dmem_if.dmem_rdata = '0;
    #2;
    chk("rst_req", 32'(dmem_if.dmem_req), 32'd0);
    chk("rst_valid", 32'(valid_out), 32'd0);
    chk("rst_mis", 32'(misaligned_out), 32'd0);
    chk("rst_read_data", read_data_out, 32'd0);
    chk("rst_wb", 32'(wb_bus_out), 32'd0);
    chk("rst_stall", 32'(stall_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) run_txn(vecs[i]);

    for (int i = 0; i < 80; i++) begin
      op       = 2'($urandom_range(0, 3));
      rv.rd    = op[0];
      rv.wr    = op[1];
      rv.sz    = 2'($urandom_range(0, 3));
      rv.uns   = 1'($urandom);
      rv.addr  = $urandom;
      rv.rt    = $urandom;
      rv.rdata = $urandom;
      rv.lat   = $urandom_range(0, 3);
      rv.mis   = (rv.rd | rv.wr) && !m_aligned(rv.sz, rv.addr);
      rv.be    = m_be(rv.sz, rv.addr);
      rv.wd    = m_wdata(rv.sz, rv.rt);
      rv.ld    = (rv.wr || !rv.rd) ? 32'd0 : m_load(rv.sz, rv.uns, rv.addr, rv.rdata);
      run_txn(rv);
    end

    // Branch resolution in IDLE.
    @(negedge clk);
    valid_in = 1'b1; memory_bus_in = 6'b000100; alu_zero_flag_in = 1'b1; next_pc_in = 32'h400;
    #1;
    chk("br_taken", 32'(pc_src_out), 32'd1);
    chk("br_target", branch_pc_out, 32'h400);
    chk("br_stall", 32'(stall_out), 32'd0);
    alu_zero_flag_in = 1'b0;
    #1;
    chk("br_not_taken", 32'(pc_src_out), 32'd0);
    @(negedge clk);
    valid_in = 1'b0;
    $display("txn branch idle pc_src checks=%0d", checks);

    // Branch presented while a load is outstanding.
    @(negedge clk);
    valid_in = 1'b1; memory_bus_in = {1'b0, SZ_WORD, 3'b001}; alu_result_in = 32'h10;
    @(posedge clk); #1;
    chk("brw_req", 32'(dmem_if.dmem_req), 32'd1);
    @(negedge clk);
    memory_bus_in = {1'b0, SZ_WORD, 3'b101}; alu_zero_flag_in = 1'b1;
    #1;
    chk("brw_pc_src", 32'(pc_src_out), 32'd0);
    chk("brw_stall", 32'(stall_out), 32'd1);
    dmem_if.dmem_ack = 1'b1;
    @(negedge clk);
    dmem_if.dmem_ack = 1'b0; valid_in = 1'b0;
    $display("txn branch in wait checks=%0d", checks);

    // Reset while waiting, then a stray ack afterwards.
    @(negedge clk);
    valid_in = 1'b1; memory_bus_in = {1'b0, SZ_WORD, 3'b001}; alu_result_in = 32'h500; wb_bus_in = 2'b11;
    @(posedge clk); #1;
    chk("rw_req_before", 32'(dmem_if.dmem_req), 32'd1);
    @(negedge clk);
    valid_in = 1'b0; rst_n = 1'b0;
    #1;
    chk("rw_req", 32'(dmem_if.dmem_req), 32'd0);
    chk("rw_addr", dmem_if.dmem_addr, 32'd0);
    chk("rw_be", 32'(dmem_if.dmem_be), 32'd0);
    chk("rw_alu_out", alu_result_out, 32'd0);
    chk("rw_stall", 32'(stall_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    dmem_if.dmem_ack = 1'b1; dmem_if.dmem_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    chk("rw_stray_valid", 32'(valid_out), 32'd0);
    chk("rw_stray_req", 32'(dmem_if.dmem_req), 32'd0);
    @(negedge clk);
    dmem_if.dmem_ack = 1'b0;
    valid_in = 1'b1; memory_bus_in = 6'b000100; alu_zero_flag_in = 1'b1;
    #1;
    chk("rw_idle_branch", 32'(pc_src_out), 32'd1);
    @(negedge clk);
    valid_in = 1'b0;
    $display("txn reset in wait checks=%0d", checks);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
MIPS pipeline MEM stage. It is the consumer of the EX/MEM register produced by the execute stage.
- Resolves branches from the EX/MEM branch bit and zero flag.
- Performs byte/half/word loads and stores to a data memory over a req/ack handshake, stalling the pipeline while an access is outstanding.
- Registers the MEM/WB outputs for the writeback stage.

Parameters:
DATA_WIDTH, 32, datapath and memory word width (fixed at 32 for lane logic)
ADDR_BITS, 32, PC and memory address width
MEM_BUS_WIDTH, 6, memory control bus: [0] mem_read, [1] mem_write, [2] branch, [4:3] size (00 byte, 01 half, 10 word, 11 treated as word), [5] load_unsigned
WB_BUS_WIDTH, 2, writeback control bus, passed through
REG_ADDR_WIDTH, 5, register-file write address width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
valid_in  in  1  EX/MEM entry holds a real instruction
memory_bus_in  in  MEM_BUS_WIDTH  memory control bus from EX/MEM
wb_bus_in  in  WB_BUS_WIDTH  writeback control from EX/MEM
alu_result_in  in  DATA_WIDTH  ALU result / effective address
reg_rt_data_in  in  DATA_WIDTH  store data
add_reg_w_in  in  REG_ADDR_WIDTH  destination register
next_pc_in  in  ADDR_BITS  branch target from EX
alu_zero_flag_in  in  1  ALU zero flag
pc_src_out  out  1  take branch (combinational)
branch_pc_out  out  ADDR_BITS  branch target (combinational, = next_pc_in)
stall_out  out  1  freeze IF/ID/EX and EX/MEM (combinational)
dmem_req  out  1  memory request (registered)
dmem_we  out  1  1 = write
dmem_addr  out  ADDR_BITS  word-aligned address
dmem_wdata  out  DATA_WIDTH  lane-replicated store data
dmem_be  out  4  byte enables
dmem_rdata  in  DATA_WIDTH  read word, valid with dmem_ack
dmem_ack  in  1  access complete
valid_out  out  1  MEM/WB entry valid
read_data_out  out  DATA_WIDTH  aligned/extended load data
alu_result_out  out  DATA_WIDTH  registered ALU result
add_reg_w_out  out  REG_ADDR_WIDTH  registered destination register
wb_bus_out  out  WB_BUS_WIDTH  registered writeback control
misaligned_out  out  1  one-cycle pulse, misaligned access suppressed

Behaviour:
Reset and state machine
- Reset is asynchronous on rst_n low. All registered outputs go to 0 and state goes to IDLE.
- Reset mid-WAIT drops dmem_req immediately. Any later dmem_ack is ignored.
- States: IDLE, WAIT.

Access start
- access = valid_in & (mem_read | mem_write).
- aligned: byte always; half requires addr[0]=0; word requires addr[1:0]=0.
- IDLE & access & aligned:
  - Capture address, store data, control and destination into holding registers.
  - Drive dmem_req=1, dmem_we=mem_write, dmem_addr={addr[31:2],00}, dmem_be and dmem_wdata from the next edge.
  - Go to WAIT. valid_out=0 that cycle.
- If mem_read and mem_write are both set, write wins (dmem_we=1); no load data is returned.

WAIT state
- Hold all dmem_* outputs stable until dmem_ack.
- On the ack edge:
  - Deassert dmem_req.
  - Register outputs from the holding registers; read_data_out = extracted load data (0 for stores).
  - valid_out=1 for one cycle, then return to IDLE.
- Minimum access latency is 2 cycles (request edge, ack edge). Ack on the first req cycle is legal.
- dmem_ack while in IDLE is ignored.

Stall
- stall_out = (IDLE & access & aligned) | (WAIT & ~dmem_ack).
- Upstream holds EX/MEM stable while stall_out=1.

Non-memory and misaligned instructions
- Non-memory valid instruction in IDLE: MEM/WB registers load at the next edge, valid_out=1, read_data_out=0, no stall.
- Misaligned access: no request is issued.
  - Next edge: valid_out=1, misaligned_out=1, wb_bus_out=0 (writeback suppressed).
- valid_in=0 in IDLE: valid_out=0 and wb_bus_out=0 at the next edge.

Branch
- pc_src_out = valid_in & branch & alu_zero_flag_in & (state==IDLE). Forced 0 in WAIT.

Store lanes (little-endian)
- Byte: wdata={4{rt[7:0]}}, be=0001<<addr[1:0].
- Half: wdata={2{rt[15:0]}}, be = addr[1] ? 1100 : 0011.
- Word: wdata=rt, be=1111.

Load extraction
- Byte: lane addr[1:0].
- Half: lane addr[1].
- Sign-extend unless load_unsigned=1, then zero-extend. Word is passed unchanged.

Decomposition:
- Shared package mips_pkg holds:
  - memory bus bit positions (MEM_READ=0, MEM_WRITE=1, BRANCH=2, SIZE_LO=3, SIZE_HI=4, LOAD_UNS=5);
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD;
  - state enum {IDLE, WAIT}.
- One combinational sub-module, mem_lane_align: store byte-enable/data replication plus load extraction/extension. Shared with a future cache.

Test Plan:
- Word store: addr 0x104, rt 0xDEADBEEF, ack 3 cycles after req → dmem_be=1111, wdata=0xDEADBEEF; stall_out high until the ack cycle; valid_out pulses once; read_data_out=0.
- Signed byte load: addr 0x203, dmem_rdata 0x80FF1234 → read_data_out=0xFFFFFF80. Same with load_unsigned=1 → 0x00000080.
- Half store/load: addr 0x302, rt 0x0000ABCD → be=1100, wdata=0xABCDABCD. Signed load of rdata 0xABCD0000 → 0xFFFFABCD.
- Misaligned word load at 0x101 → no dmem_req; next cycle valid_out=1, misaligned_out=1, wb_bus_out=0; stall_out never asserted.
- Branch: branch=1, zero=1, next_pc_in=0x400 in IDLE → pc_src_out=1, branch_pc_out=0x400 same cycle. zero=0 → pc_src_out=0. Branch presented while in WAIT → 0.
- rst_n low during WAIT → dmem_req=0 and all outputs 0 immediately; dmem_ack pulse after rst_n rises → no valid_out, state remains IDLE.
